// File: rtl/sram_ctrl_pkg.sv
// Shared types for the SRAM byte-row sequencer and its round-robin arbiter.
package sram_ctrl_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      PULSE,
      HOLD,
      DONE
   } state_t;

   typedef enum logic {
      PORT_A,
      PORT_B
   } port_t;

endpackage

// File: rtl/sram_byte_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter: combinational grant, pointer update proposal.
module rr_arb2
   import sram_ctrl_pkg::*;
(
   input  logic [1:0] req,
   input  port_t      ptr,
   input  logic       en,
   output logic [1:0] grant,
   output port_t      next_ptr
);

   always_comb begin
      grant    = '0;
      next_ptr = ptr;
      if (en) begin
         case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (ptr == PORT_A) ? 2'b01 : 2'b10;
            default: grant = '0;
         endcase
      end
      // The pointer always moves to the port that was not just served.
      if (grant[0]) begin
         next_ptr = PORT_B;
      end else if (grant[1]) begin
         next_ptr = PORT_A;
      end
   end

endmodule

// File: rtl/sram_byte_ctrl.sv
// Two-port request sequencer driving word lines, data and read/write strobes of a byte-row SRAM.
module sram_byte_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int ADDR_W       = 4,
   parameter int PULSE_CYCLES = 2
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     a_req,
   input  logic                     a_we,
   input  logic [ADDR_W-1:0]        a_addr,
   input  logic [7:0]               a_wdata,
   output logic                     a_ack,
   output logic [7:0]               a_rdata,
   input  logic                     b_req,
   input  logic                     b_we,
   input  logic [ADDR_W-1:0]        b_addr,
   input  logic [7:0]               b_wdata,
   output logic                     b_ack,
   output logic [7:0]               b_rdata,
   output logic [(1<<ADDR_W)-1:0]   wl,
   output logic [7:0]               sram_din,
   input  logic [7:0]               sram_dout,
   output logic                     read_pulse,
   output logic                     write_pulse,
   output logic                     busy
);

   localparam int               NUM_WORDS = 1 << ADDR_W;
   localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(PULSE_CYCLES - 1);

   state_t            state;
   port_t             rr_ptr;
   port_t             next_ptr;
   port_t             cur_port;
   logic              cur_we;
   logic [CNT_W-1:0]  cnt;
   logic [1:0]        grant;
   logic              arb_en;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [7:0]        sel_wdata;

   assign arb_en = (state == IDLE);

   rr_arb2 u_arb (
      .req      ({b_req, a_req}),
      .ptr      (rr_ptr),
      .en       (arb_en),
      .grant    (grant),
      .next_ptr (next_ptr)
   );

   always_comb begin
      sel_we    = a_we;
      sel_addr  = a_addr;
      sel_wdata = a_wdata;
      if (grant[1]) begin
         sel_we    = b_we;
         sel_addr  = b_addr;
         sel_wdata = b_wdata;
      end
   end

   // The granted address and write data are latched directly as the decoded
   // word lines and the array data bus, which then hold until DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rr_ptr      <= PORT_A;
         cur_port    <= PORT_A;
         cur_we      <= 1'b0;
         cnt         <= '0;
         wl          <= '0;
         sram_din    <= '0;
         read_pulse  <= 1'b0;
         write_pulse <= 1'b0;
         a_ack       <= 1'b0;
         b_ack       <= 1'b0;
         a_rdata     <= '0;
         b_rdata     <= '0;
         busy        <= 1'b0;
      end else begin
         a_ack <= 1'b0;
         b_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (|grant) begin
                  state    <= SETUP;
                  busy     <= 1'b1;
                  rr_ptr   <= next_ptr;
                  cur_port <= grant[1] ? PORT_B : PORT_A;
                  cur_we   <= sel_we;
                  wl       <= NUM_WORDS'(1) << sel_addr;
                  sram_din <= sel_we ? sel_wdata : '0;
               end
            end
            SETUP: begin
               state       <= PULSE;
               cnt         <= CNT_LOAD;
               write_pulse <= cur_we;
               read_pulse  <= ~cur_we;
            end
            PULSE: begin
               if (cnt == '0) begin
                  state       <= HOLD;
                  write_pulse <= 1'b0;
                  read_pulse  <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            HOLD: begin
               state    <= DONE;
               wl       <= '0;
               sram_din <= '0;
               if (cur_port == PORT_A) begin
                  a_ack <= 1'b1;
                  if (!cur_we) a_rdata <= sram_dout;
               end else begin
                  b_ack <= 1'b1;
                  if (!cur_we) b_rdata <= sram_dout;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_byte_ctrl.sv
// Bench for sram_byte_ctrl: three instances (pulse widths 2, 1, 15) against a byte-array and reference model.
module tb_sram_byte_ctrl;

   logic clk = 1'b0;
   logic rst_n;

   logic        a_req [3];
   logic        a_we [3];
   logic [3:0]  a_addr [3];
   logic [7:0]  a_wdata [3];
   logic        a_ack [3];
   logic [7:0]  a_rdata [3];
   logic        b_req [3];
   logic        b_we [3];
   logic [3:0]  b_addr [3];
   logic [7:0]  b_wdata [3];
   logic        b_ack [3];
   logic [7:0]  b_rdata [3];
   logic [15:0] wl [3];
   logic [7:0]  sram_din [3];
   logic [7:0]  sram_dout [3] = '{default: '0};
   logic        read_pulse [3];
   logic        write_pulse [3];
   logic        busy [3];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      sram_byte_ctrl #(
         .ADDR_W       (4),
         .PULSE_CYCLES (g == 0 ? 2 : (g == 1 ? 1 : 15))
      ) u_dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .a_req       (a_req[g]),
         .a_we        (a_we[g]),
         .a_addr      (a_addr[g]),
         .a_wdata     (a_wdata[g]),
         .a_ack       (a_ack[g]),
         .a_rdata     (a_rdata[g]),
         .b_req       (b_req[g]),
         .b_we        (b_we[g]),
         .b_addr      (b_addr[g]),
         .b_wdata     (b_wdata[g]),
         .b_ack       (b_ack[g]),
         .b_rdata     (b_rdata[g]),
         .wl          (wl[g]),
         .sram_din    (sram_din[g]),
         .sram_dout   (sram_dout[g]),
         .read_pulse  (read_pulse[g]),
         .write_pulse (write_pulse[g]),
         .busy        (busy[g])
      );
   end

   function automatic int pc(input int i);
      return (i == 0) ? 2 : ((i == 1) ? 1 : 15);
   endfunction

   function automatic int row_of(input logic [15:0] w);
      for (int k = 0; k < 16; k++) if (w[k]) return k;
      return 0;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Byte array: writes on strobe, read data latched by the read strobe.
   logic [7:0] arr [3][16] = '{default: '0};
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (write_pulse[i]) arr[i][row_of(wl[i])] <= sram_din[i];
         if (read_pulse[i])  sram_dout[i] <= arr[i][row_of(wl[i])];
      end
   end

   // Strobe width / word-line capture and invariants.
   int          pcnt [3] = '{default: 0};
   int          pw [3] = '{default: 0};
   logic        pkind [3] = '{default: 1'b0};
   logic [15:0] wl_cap [3] = '{default: '0};
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("inv%0d_both_pulses", i), 64'(read_pulse[i] && write_pulse[i]), 0);
         chk($sformatf("inv%0d_pulse_no_wl", i), 64'((read_pulse[i] || write_pulse[i]) && wl[i] == '0), 0);
         chk($sformatf("inv%0d_wl_onehot0", i), 64'($onehot0(wl[i])), 1);
         if (read_pulse[i] || write_pulse[i]) begin
            pcnt[i]   <= pcnt[i] + 1;
            wl_cap[i] <= wl[i];
            pkind[i]  <= write_pulse[i];
         end else if (pcnt[i] != 0) begin
            pw[i]   <= pcnt[i];
            pcnt[i] <= 0;
         end
      end
   end

   logic [7:0] ref_mem [3][16] = '{default: '0};
   logic [7:0] ref_rd [3][2] = '{default: '0};

   // Single-port transaction from an idle controller; called just after a sampling point.
   task automatic op(input int i, input int p, input logic we, input logic [3:0] addr, input logic [7:0] d);
      int n;
      logic got;
      logic [1:0] acks;
      logic [15:0] exp_wl;
      if (p == 0) begin
         a_req[i] = 1'b1; a_we[i] = we; a_addr[i] = addr; a_wdata[i] = d;
      end else begin
         b_req[i] = 1'b1; b_we[i] = we; b_addr[i] = addr; b_wdata[i] = d;
      end
      n = 0; got = 1'b0; acks = '0;
      while (!got && n < 40) begin
         @(posedge clk); #1; n++;
         acks = {a_ack[i], b_ack[i]};
         if (acks != 2'b00) got = 1'b1;
      end
      a_req[i] = 1'b0;
      b_req[i] = 1'b0;
      chk($sformatf("op%0d_ack_port", i), 64'(acks), (p == 0) ? 64'd2 : 64'd1);
      chk($sformatf("op%0d_latency", i), 64'(n), 64'(pc(i) + 3));
      if (we) ref_mem[i][addr] = d;
      else    ref_rd[i][p] = ref_mem[i][addr];
      chk($sformatf("op%0d_a_rdata", i), 64'(a_rdata[i]), 64'(ref_rd[i][0]));
      chk($sformatf("op%0d_b_rdata", i), 64'(b_rdata[i]), 64'(ref_rd[i][1]));
      chk($sformatf("op%0d_pulse_width", i), 64'(pw[i]), 64'(pc(i)));
      chk($sformatf("op%0d_pulse_kind", i), 64'(pkind[i]), 64'(we));
      exp_wl = 16'd1 << addr;
      chk($sformatf("op%0d_wl", i), 64'(wl_cap[i]), 64'(exp_wl));
      @(posedge clk); #1;
      chk($sformatf("op%0d_ack_low", i), 64'({a_ack[i], b_ack[i]}), 0);
      chk($sformatf("op%0d_busy_idle", i), 64'(busy[i]), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int nack;
      logic got;
      logic [1:0] acks;
      int p;
      logic we;
      logic [3:0] addr;
      logic [7:0] d;

      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a_req[i] = 1'b0; a_we[i] = 1'b0; a_addr[i] = '0; a_wdata[i] = '0;
         b_req[i] = 1'b0; b_we[i] = 1'b0; b_addr[i] = '0; b_wdata[i] = '0;
      end
      // Both ports of instance 0 request reads from reset release onward.
      a_req[0] = 1'b1; a_addr[0] = 4'd0;
      b_req[0] = 1'b1; b_addr[0] = 4'd1;

      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("reset%0d_outputs", i),
             {wl[i], sram_din[i], read_pulse[i], write_pulse[i], a_ack[i], b_ack[i], a_rdata[i], b_rdata[i], busy[i]}, 0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Simultaneous requests: A, B, A, B with 6-cycle spacing.
      n = 0; nack = 0;
      while (nack < 4 && n < 60) begin
         @(posedge clk); #1; n++;
         if (a_ack[0] || b_ack[0]) begin
            chk("sim_port", 64'({a_ack[0], b_ack[0]}), (nack % 2 == 0) ? 64'd2 : 64'd1);
            chk("sim_edge", 64'(n), 64'(5 + 6 * nack));
            nack++;
            if (nack == 4) begin
               a_req[0] = 1'b0;
               b_req[0] = 1'b0;
            end
         end
      end
      chk("sim_count", 64'(nack), 4);
      ref_rd[0][0] = ref_mem[0][0];
      ref_rd[0][1] = ref_mem[0][1];
      @(posedge clk); #1;
      chk("sim_ack_low", 64'({a_ack[0], b_ack[0]}), 0);

      // Write then read on port A.
      op(0, 0, 1'b1, 4'd3, 8'hA5);
      op(0, 0, 1'b0, 4'd3, 8'h00);

      // Port B alone, once with pointer at B and once with pointer at A.
      op(0, 1, 1'b1, 4'd7, 8'h5A);
      op(0, 1, 1'b0, 4'd7, 8'h00);

      // Request held past ack starts a second operation.
      a_req[0] = 1'b1; a_we[0] = 1'b0; a_addr[0] = 4'd3;
      n = 0; got = 1'b0;
      while (!got && n < 40) begin
         @(posedge clk); #1; n++;
         if (a_ack[0]) got = 1'b1;
      end
      chk("held_first_latency", 64'(n), 5);
      chk("held_first_rdata", 64'(a_rdata[0]), 64'(ref_mem[0][3]));
      @(posedge clk); #1;
      chk("held_idle_ack_low", 64'(a_ack[0]), 0);
      @(posedge clk); #1;
      a_req[0] = 1'b0;
      n = 0; got = 1'b0;
      while (!got && n < 40) begin
         @(posedge clk); #1; n++;
         if (a_ack[0]) got = 1'b1;
      end
      chk("held_second_latency", 64'(n), 4);
      ref_rd[0][0] = ref_mem[0][3];
      chk("held_second_rdata", 64'(a_rdata[0]), 64'(ref_rd[0][0]));
      chk("held_b_rdata", 64'(b_rdata[0]), 64'(ref_rd[0][1]));
      @(posedge clk); #1;
      chk("held_ack_low", 64'(a_ack[0]), 0);

      // Reset during the write strobe drops the operation.
      a_req[0] = 1'b1; a_we[0] = 1'b1; a_addr[0] = 4'd5; a_wdata[0] = 8'h3C;
      n = 0; got = 1'b0;
      while (!got && n < 10) begin
         @(posedge clk); #1; n++;
         if (write_pulse[0]) got = 1'b1;
      end
      chk("rst_reached_pulse", 64'(got), 1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_outputs",
          {wl[0], sram_din[0], read_pulse[0], write_pulse[0], a_ack[0], b_ack[0], a_rdata[0], b_rdata[0], busy[0]}, 0);
      a_req[0] = 1'b0;
      ref_rd = '{default: '0};
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("rst_no_ack", 64'({a_ack[0], b_ack[0], busy[0]}), 0);
      end
      a_req[0] = 1'b1; a_we[0] = 1'b0; a_addr[0] = 4'd5;
      b_req[0] = 1'b1; b_we[0] = 1'b0; b_addr[0] = 4'd3;
      n = 0; nack = 0;
      while (nack < 2 && n < 40) begin
         @(posedge clk); #1; n++;
         acks = {a_ack[0], b_ack[0]};
         if (acks != 2'b00) begin
            chk("rst_after_port", 64'(acks), (nack == 0) ? 64'd2 : 64'd1);
            chk("rst_after_edge", 64'(n), 64'(5 + 6 * nack));
            if (nack == 0) a_req[0] = 1'b0;
            else           b_req[0] = 1'b0;
            nack++;
         end
      end
      chk("rst_after_count", 64'(nack), 2);
      ref_rd[0][0] = ref_mem[0][5];
      ref_rd[0][1] = ref_mem[0][3];
      chk("rst_after_a_rdata", 64'(a_rdata[0]), 64'(ref_rd[0][0]));
      chk("rst_after_b_rdata", 64'(b_rdata[0]), 64'(ref_rd[0][1]));
      @(posedge clk); #1;

      // Pulse width extremes.
      for (int i = 1; i < 3; i++) begin
         op(i, 0, 1'b1, 4'd9, 8'hC3);
         op(i, 1, 1'b0, 4'd9, 8'h00);
         op(i, 0, 1'b0, 4'd15, 8'h00);
      end

      // Random single-port traffic on every instance.
      for (int i = 0; i < 3; i++) begin
         for (int k = 0; k < 10; k++) begin
            p    = int'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            addr = 4'($urandom_range(0, 15));
            d    = 8'($urandom_range(0, 255));
            op(i, p, we, addr, d);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sram_byte_ctrl.md
Name: sram_byte_ctrl

Overview:
- Sequencer and two-port arbiter for a bank of 2**ADDR_W SRAM byte rows.
- Accepts word read/write requests from two requesters: port A (fetch side) and port B (load/store side).
- Arbitrates the requests round-robin. Drives the one-hot word lines, the write data, and the read/write pulses into the byte array.
- Captures the array's read data and returns it with a one-cycle acknowledge.

Parameters:
- ADDR_W, 4, row address width; NUM_WORDS = 2**ADDR_W word lines.
- PULSE_CYCLES, 2, cycles read_pulse/write_pulse is held high; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a_req  input  1  port A request; held until a_ack.
- a_we  input  1  port A write enable (1 = write, 0 = read).
- a_addr  input  ADDR_W  port A row address.
- a_wdata  input  8  port A write data.
- a_ack  output  1  port A completion pulse.
- a_rdata  output  8  port A read data, valid while a_ack = 1.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: as for port A.
- wl  output  NUM_WORDS  one-hot word lines to the rows.
- sram_din  output  8  write data to the array.
- sram_dout  input  8  read data from the array.
- read_pulse  output  1  array read strobe.
- write_pulse  output  1  array write strobe.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset, asynchronous and active-low; it forces, immediately and at any point mid-operation:
  - state = IDLE, rr_ptr = A;
  - wl = 0, sram_din = 0, read_pulse = 0, write_pulse = 0;
  - a_ack = b_ack = 0, a_rdata = b_rdata = 0, busy = 0;
  - any in-flight operation is dropped with no ack.
- States: IDLE -> SETUP -> PULSE -> HOLD -> DONE -> IDLE.
- IDLE:
  - Samples a_req/b_req on each edge.
  - If exactly one is high, that port is granted.
  - If both are high, the port named by rr_ptr is granted.
  - On a grant: latch we, addr and wdata from the granted port; next state SETUP; rr_ptr <= the other port.
- SETUP, one cycle:
  - wl = one-hot(latched addr).
  - sram_din = latched wdata for a write, 0 for a read.
  - Both pulses low.
- PULSE, exactly PULSE_CYCLES cycles, counted by a 4-bit down-counter:
  - wl and sram_din held.
  - write_pulse = we; read_pulse = ~we.
- HOLD, one cycle:
  - Pulses low; wl and sram_din held.
  - For a read, sram_dout is registered into the granted port's rdata at the end of HOLD.
- DONE, one cycle:
  - wl = 0, sram_din = 0.
  - The granted port's ack = 1; the other port's ack stays 0.
  - rdata holds its value until the next read for that port.
  - For a write, rdata is unchanged.
- Latency: req sampled at edge t -> ack high during cycle t+3+PULSE_CYCLES (cycle t+5 at the default).
- Requester protocol:
  - req, we, addr and wdata changes after the grant are ignored.
  - A req still high at the IDLE edge following DONE is a new request.
  - Minimum spacing between grants: 4+PULSE_CYCLES cycles.
- Signal invariants:
  - Never both pulses high.
  - A pulse is never high while wl = 0.
  - wl is 0 or one-hot at all times.
- Every ADDR_W value maps to a row, so there is no out-of-range case.

Decomposition:
- Package sram_ctrl_pkg:
  - state_t enum {IDLE, SETUP, PULSE, HOLD, DONE};
  - port_t enum {PORT_A, PORT_B};
  - localparam CNT_W = 4.
- Sub-module rr_arb2:
  - inputs: req[1:0], ptr, en;
  - outputs: grant one-hot[1:0], next_ptr;
  - combinational grant, registered pointer inside the controller.
- The one-hot decode of wl stays inline.

Test Plan:
- Write then read, PULSE_CYCLES = 2:
  - A writes 0xA5 to addr 3 -> wl = 0x0008 over SETUP/PULSE/HOLD; write_pulse high exactly 2 cycles; a_ack at t+5.
  - A then reads addr 3 -> a_rdata = 0xA5 with a_ack.
- Simultaneous requests:
  - a_req and b_req both held high from reset release -> grants go A, B, A, B.
  - Each ack is 1 cycle; grants are 6 cycles apart.
- Single-port priority:
  - Only b_req high with rr_ptr = B -> B is granted.
  - b_req high with rr_ptr = A and a_req low -> B is still granted next IDLE.
- Reset mid-PULSE:
  - Assert rst_n = 0 during PULSE of a write -> all outputs 0 immediately; no ack.
  - After release, state is IDLE and the next simultaneous request is granted to A.
- Parameter sweep:
  - PULSE_CYCLES = 1 and 15 -> pulse widths of 1 and 15 cycles; ack at t+4 and t+18.
  - read_pulse and write_pulse are never both high.
- Request held past ack:
  - a_req stays high one cycle past a_ack -> a second operation starts at the next IDLE edge.
  - b_rdata is unaffected.
